// File: rtl/snd_mix.sv
// snd_mix: time-multiplexed expansion-audio mixer feeding the delta-sigma DAC.
// Once per M2 rising edge the channel samples and gains are snapshotted, then
// multiplied and accumulated one channel per clk, and the saturated 16-bit
// level is published on snd together with a one-clock snd_stb pulse.
module snd_mix #(
    parameter int CHANNELS = 4,
    parameter int CH_W     = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     m2,
    input  logic [CHANNELS*CH_W-1:0] ch_in,
    input  logic [CHANNELS*4-1:0]    ch_gain,
    input  logic                     mute,
    output logic [15:0]              snd,
    output logic                     snd_stb,
    output logic                     busy,
    output logic [7:0]               drop_cnt
);

    // Accumulator is sized so the sum of all full-scale products cannot wrap.
    localparam int ACC_W  = CH_W + 4 + $clog2(CHANNELS);
    localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PROD_W = CH_W + 4;

    typedef enum logic [1:0] {IDLE, SUM, OUT} state_t;

    state_t                           state;
    logic [1:0]                       m2_st;
    logic                             m2_rise;
    logic [CHANNELS-1:0][CH_W-1:0]    samp;
    logic [CHANNELS-1:0][3:0]         gain;
    logic [ACC_W-1:0]                 acc;
    logic [IDX_W-1:0]                 idx;
    logic [PROD_W-1:0]                prod;
    logic [31:0]                      lvl;
    logic                             lvl_sat;

    assign m2_rise = (m2_st == 2'b01);
    assign busy    = (state != IDLE);

    // Product of the channel currently selected by idx.
    assign prod    = PROD_W'(samp[idx]) * PROD_W'(gain[idx]);

    // Gains are in 1/8 units, so drop three fraction bits (floor) and clamp.
    assign lvl     = 32'(acc >> 3);
    assign lvl_sat = |lvl[31:16];

    // Two-flop synchroniser for the asynchronous M2 pin.
    always_ff @(posedge clk) begin
        if (rst) m2_st <= 2'b00;
        else     m2_st <= {m2_st[0], m2};
    end

    // Mix sequencer: snapshot on an M2 edge, serial multiply-accumulate, publish.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            samp     <= '0;
            gain     <= '0;
            acc      <= '0;
            idx      <= '0;
            snd      <= 16'd0;
            snd_stb  <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            snd_stb <= 1'b0;
            // Edges arriving mid-mix are not queued, only counted.
            if (m2_rise && state != IDLE && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
            case (state)
                IDLE: begin
                    if (m2_rise) begin
                        samp  <= ch_in;
                        gain  <= ch_gain;
                        acc   <= '0;
                        idx   <= '0;
                        state <= SUM;
                    end
                end
                SUM: begin
                    acc <= acc + ACC_W'(prod);
                    if (idx == IDX_W'(CHANNELS - 1)) state <= OUT;
                    else                             idx   <= idx + 1'b1;
                end
                OUT: begin
                    // mute is looked at only here, so a mid-mix assert still zeroes it.
                    if (mute)         snd <= 16'd0;
                    else if (lvl_sat) snd <= 16'hFFFF;
                    else              snd <= lvl[15:0];
                    snd_stb <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snd_mix.sv
// tb_snd_mix: directed and randomized checks of snd_mix against a plain
// arithmetic reference model, on a 4-channel and a 16-channel instance that
// share clk, rst, m2 and mute.
module tb_snd_mix;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         m2  = 1'b0;
    logic         mute = 1'b0;
    logic [47:0]  in4  = '0;
    logic [15:0]  g4   = '0;
    logic [191:0] in16 = '0;
    logic [63:0]  g16  = '0;

    logic [15:0]  snd4, snd16;
    logic         stb4, stb16, busy4, busy16;
    logic [7:0]   drop4, drop16;

    int ncmp = 0;
    int nfail = 0;
    int cyc = 0;
    int stb4_cnt = 0, stb16_cnt = 0;
    int stb4_cyc = 0, stb16_cyc = 0;
    bit prev4 = 0, prev16 = 0, b2b = 0;
    logic [15:0] last_e4 = '0, last_e16 = '0;

    snd_mix #(.CHANNELS(4), .CH_W(12)) u4 (
        .clk(clk), .rst(rst), .m2(m2), .ch_in(in4), .ch_gain(g4), .mute(mute),
        .snd(snd4), .snd_stb(stb4), .busy(busy4), .drop_cnt(drop4)
    );

    snd_mix #(.CHANNELS(16), .CH_W(12)) u16 (
        .clk(clk), .rst(rst), .m2(m2), .ch_in(in16), .ch_gain(g16), .mute(mute),
        .snd(snd16), .snd_stb(stb16), .busy(busy16), .drop_cnt(drop16)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (stb4)  begin stb4_cnt++;  stb4_cyc  = cyc; end
        if (stb16) begin stb16_cnt++; stb16_cyc = cyc; end
        if ((stb4 && prev4) || (stb16 && prev16)) b2b = 1;
        prev4  = stb4;
        prev16 = stb16;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: weighted sum in 1/8 units, floored, clamped, or 0 when muted.
    function automatic logic [15:0] ref_mix(input logic [191:0] s, input logic [63:0] g,
                                            input int n, input bit mt);
        longint sum = 0;
        longint l;
        for (int i = 0; i < n; i++)
            sum += longint'(s[i*12 +: 12]) * longint'(g[i*4 +: 4]);
        l = sum / 8;
        if (mt) return 16'd0;
        if (l > 65535) return 16'hFFFF;
        return 16'(l);
    endfunction

    function automatic logic [191:0] rnd_s();
        logic [191:0] v;
        for (int i = 0; i < 16; i++) v[i*12 +: 12] = 12'($urandom);
        return v;
    endfunction

    function automatic logic [63:0] rnd_g();
        logic [63:0] v;
        for (int i = 0; i < 16; i++) v[i*4 +: 4] = 4'($urandom);
        return v;
    endfunction

    // One M2 period of 28 clk (14 high, 14 low) with optional mid-mix actions.
    task automatic do_mix(input string tag, input logic [47:0] s4, input logic [15:0] gg4,
                          input logic [191:0] s16, input logic [63:0] gg16,
                          input bit mute_mid, input bit chg);
        logic [15:0] e4, e16;
        int c4, c16, t0;
        e4  = ref_mix({144'd0, s4}, {48'd0, gg4}, 4, mute_mid);
        e16 = ref_mix(s16, gg16, 16, mute_mid);
        in4 = s4; g4 = gg4; in16 = s16; g16 = gg16;
        c4  = stb4_cnt;
        c16 = stb16_cnt;
        m2  = 1'b1;
        t0  = cyc;
        for (int j = 1; j <= 14; j++) begin
            @(negedge clk);
            if (chg && j == 3) begin in4 = '0; in16 = '0; end
            if (mute_mid && j == 4) mute = 1'b1;
        end
        m2 = 1'b0;
        repeat (14) @(negedge clk);
        mute = 1'b0;
        check({tag, "_stb4"},  stb4_cnt - c4, 1);
        check({tag, "_stb16"}, stb16_cnt - c16, 1);
        check({tag, "_snd4"},  snd4, e4);
        check({tag, "_snd16"}, snd16, e16);
        check({tag, "_lat4"},  stb4_cyc - t0, 7);
        check({tag, "_lat16"}, stb16_cyc - t0, 19);
        check({tag, "_idle4"}, busy4, 0);
        last_e4  = e4;
        last_e16 = e16;
    endtask

    initial begin
        logic [191:0] s;
        logic [63:0]  g;
        int c4, c16, t0, drops, acc4, acc16, lk4, lk16, d4;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_snd4", snd4, 0);
        check("rst_snd16", snd16, 0);
        check("rst_stb", {stb4, stb16}, 0);
        check("rst_busy", {busy4, busy16}, 0);
        check("rst_drop", {drop4, drop16}, 0);
        repeat (5) @(negedge clk);

        // Basic mix and gain/floor
        do_mix("basic", {12'd400, 12'd300, 12'd200, 12'd100}, 16'h8888, rnd_s(), rnd_g(), 0, 0);
        do_mix("floor", {12'd7, 12'd1, 12'd0, 12'd4095}, {4'd3, 4'd1, 4'd15, 4'd15},
               rnd_s(), rnd_g(), 0, 0);
        // Saturation, all zero samples, zero gains
        do_mix("sat", {4{12'd4095}}, 16'hFFFF, {16{12'd4095}}, {16{4'd15}}, 0, 0);
        s = rnd_s(); g = rnd_g();
        do_mix("zero_s", 48'd0, g[15:0], 192'd0, g, 0, 0);
        do_mix("zero_g", s[47:0], 16'd0, s, 64'd0, 0, 0);
        // Snapshot: inputs cleared right after capture; then mute during SUM
        s = rnd_s(); g = rnd_g();
        do_mix("snap", s[47:0], g[15:0], s, g, 0, 1);
        s = rnd_s(); g = rnd_g();
        do_mix("mute", s[47:0], g[15:0], s, g, 1, 0);

        // Reset mid-SUM: no strobe, outputs cleared
        s = rnd_s(); g = rnd_g();
        in4 = s[47:0]; g4 = g[15:0]; in16 = s; g16 = g;
        c4 = stb4_cnt; c16 = stb16_cnt;
        m2 = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        m2  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("rstmid_stb", (stb4_cnt - c4) + (stb16_cnt - c16), 0);
        check("rstmid_snd4", snd4, 0);
        check("rstmid_snd16", snd16, 0);
        check("rstmid_busy", {busy4, busy16}, 0);
        s = rnd_s(); g = rnd_g();
        do_mix("post_rst", s[47:0], g[15:0], s, g, 0, 0);

        // Randomized mixes, some muted mid-SUM
        for (int r = 0; r < 20; r++) begin
            s = rnd_s(); g = rnd_g();
            do_mix($sformatf("rnd%0d", r), s[47:0], g[15:0], s, g, ($urandom_range(0, 4) == 0), 0);
        end

        // M2 stopped: output holds, no strobes
        c4 = stb4_cnt; c16 = stb16_cnt;
        repeat (60) @(negedge clk);
        check("stop_stb", (stb4_cnt - c4) + (stb16_cnt - c16), 0);
        check("stop_snd4", snd4, last_e4);
        check("stop_snd16", snd16, last_e16);

        // Drop: 12-clk M2 period, edges landing while busy are dropped
        s = rnd_s(); g = rnd_g();
        in4 = s[47:0]; g4 = g[15:0]; in16 = s; g16 = g;
        c4 = stb4_cnt; c16 = stb16_cnt;
        drops = 0; d4 = 0; acc4 = 0; acc16 = 0; lk4 = -1000; lk16 = -1000;
        for (int p = 0; p < 520; p++) begin
            m2 = 1'b1;
            t0 = cyc + 2;  // detection edge
            if (t0 <= lk16 + 17) drops++; else begin acc16++; lk16 = t0; end
            if (t0 <= lk4 + 5)   d4++;    else begin acc4++;  lk4  = t0; end
            repeat (6) @(negedge clk);
            m2 = 1'b0;
            repeat (6) @(negedge clk);
            if (p == 9) begin
                check("drop16_early", drop16, drops);
                check("drop4_early", drop4, d4);
            end
        end
        repeat (30) @(negedge clk);
        check("drop16_sat", drop16, (drops > 255) ? 255 : drops);
        check("drop4_none", drop4, d4);
        check("drop_stb16", stb16_cnt - c16, acc16);
        check("drop_stb4", stb4_cnt - c4, acc4);
        check("drop_snd16", snd16, ref_mix(s, g, 16, 0));
        check("drop_snd4", snd4, ref_mix({144'd0, s[47:0]}, {48'd0, g[15:0]}, 4, 0));

        check("no_b2b_stb", b2b, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
